// File: rtl/tiny_io_pkg.sv
// Shared I/O-space definitions for the tiny port blocks: register addresses,
// default pin count and bus data types.
package tiny_io_pkg;

    typedef logic [5:0] io_addr_t;
    typedef logic [7:0] io_data_t;

    localparam int       IO_NPINS      = 6;
    localparam io_addr_t IO_ADDR_PCMSK = 6'h15;
    localparam io_addr_t IO_ADDR_PINB  = 6'h16;
    localparam io_addr_t IO_ADDR_DDRB  = 6'h17;
    localparam io_addr_t IO_ADDR_PORTB = 6'h18;

endpackage

// File: rtl/tiny_pin_sync.sv
// Multi-stage synchroniser for asynchronous pad levels, synchronous reset.
// STAGES must be at least 2.
module tiny_pin_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tiny_portb_regs.sv
// Port-B register responder: PORTB/DDRB/PINB/PCMSK access, pad input
// synchronisation and pin-change interrupt generation.
module tiny_portb_regs
    import tiny_io_pkg::*;
#(
    parameter int       NPINS       = IO_NPINS,
    parameter io_addr_t ADDR_PCMSK  = IO_ADDR_PCMSK,
    parameter io_addr_t ADDR_PINB   = IO_ADDR_PINB,
    parameter io_addr_t ADDR_DDRB   = IO_ADDR_DDRB,
    parameter io_addr_t ADDR_PORTB  = IO_ADDR_PORTB,
    parameter int       SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  io_addr_t         addr,
    input  logic             wr_en,
    input  io_data_t         wdata,
    input  logic             rd_en,
    output io_data_t         rdata,
    output logic             rvalid,
    input  logic [NPINS-1:0] pin_in,
    output logic [NPINS-1:0] port_out,
    output logic [NPINS-1:0] pin_oe,
    output logic             pc_irq,
    input  logic             irq_ack
);

    localparam logic [1:0] WARM_MAX = 2'(SYNC_STAGES + 1);

    logic [NPINS-1:0] port_q, port_d;
    logic [NPINS-1:0] ddr_q, ddr_d;
    logic [NPINS-1:0] pcmsk_q, pcmsk_d;
    logic [NPINS-1:0] prev_q;
    logic [NPINS-1:0] pin_sync;
    io_data_t         rdata_q, rdata_d;
    logic             rvalid_q;
    logic             pc_irq_q, pc_irq_d;
    logic [1:0]       warm_q, warm_d;
    logic             warm_done;
    logic             chg;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    tiny_pin_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (NPINS)
    ) u_pin_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pin_in),
        .q_o (pin_sync)
    );

    always_comb begin
        port_d  = port_q;
        ddr_d   = ddr_q;
        pcmsk_d = pcmsk_q;
        if (wr_en) begin
            case (addr)
                ADDR_PORTB: port_d  = wdata[NPINS-1:0];
                ADDR_DDRB:  ddr_d   = wdata[NPINS-1:0];
                ADDR_PCMSK: pcmsk_d = wdata[NPINS-1:0];
                // Writing 1s to PINB toggles the matching PORTB bits.
                ADDR_PINB:  port_d  = port_q ^ wdata[NPINS-1:0];
                default:    ;
            endcase
        end
    end

    // Read mux samples pre-write values, so a same-cycle write is not seen.
    always_comb begin
        rdata_d = '0;
        case (addr)
            ADDR_PORTB: rdata_d[NPINS-1:0] = port_q;
            ADDR_DDRB:  rdata_d[NPINS-1:0] = ddr_q;
            ADDR_PCMSK: rdata_d[NPINS-1:0] = pcmsk_q;
            ADDR_PINB:  rdata_d[NPINS-1:0] = pin_sync;
            default:    ;
        endcase
    end

    assign warm_done = (warm_q == WARM_MAX);
    assign warm_d    = warm_done ? warm_q : warm_q + 2'd1;
    assign chg       = |((pin_sync ^ prev_q) & pcmsk_q);

    // Set has priority over acknowledge.
    always_comb begin
        pc_irq_d = pc_irq_q;
        if (irq_ack) begin
            pc_irq_d = 1'b0;
        end
        if (chg && warm_done) begin
            pc_irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q   <= '0;
            ddr_q    <= '0;
            pcmsk_q  <= '0;
            prev_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            pc_irq_q <= 1'b0;
            warm_q   <= '0;
        end else begin
            port_q   <= port_d;
            ddr_q    <= ddr_d;
            pcmsk_q  <= pcmsk_d;
            prev_q   <= pin_sync;
            rvalid_q <= rd_en;
            pc_irq_q <= pc_irq_d;
            warm_q   <= warm_d;
            if (rd_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign port_out = port_q;
    assign pin_oe   = ddr_q;
    assign pc_irq   = pc_irq_q;

endmodule

// File: tb/tb_tiny_portb_regs.sv
// Directed bench for tiny_portb_regs with hand-computed expectations.
module tb_tiny_portb_regs;
    import tiny_io_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] addr;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rvalid;
    logic [5:0] pin_in;
    logic [5:0] port_out;
    logic [5:0] pin_oe;
    logic       pc_irq;
    logic       irq_ack;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tiny_portb_regs dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .pin_in   (pin_in),
        .port_out (port_out),
        .pin_oe   (pin_oe),
        .pc_irq   (pc_irq),
        .irq_ack  (irq_ack)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
        addr  = a;
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk({tag, "_rvalid"}, {7'd0, rvalid}, 8'h01);
        chk(tag, rdata, exp);
    endtask

    initial begin
        rst     = 1'b1;
        addr    = '0;
        wr_en   = 1'b0;
        wdata   = '0;
        rd_en   = 1'b0;
        pin_in  = 6'h3F;
        irq_ack = 1'b0;

        repeat (2) cyc();
        chk("rst_port_out", {2'b0, port_out}, 8'h00);
        chk("rst_pin_oe",   {2'b0, pin_oe},   8'h00);
        chk("rst_pc_irq",   {7'd0, pc_irq},   8'h00);
        chk("rst_rvalid",   {7'd0, rvalid},   8'h00);

        // Continuous PINB read across synchroniser warm-up
        rst   = 1'b0;
        addr  = IO_ADDR_PINB;
        rd_en = 1'b1;
        cyc();
        chk("warm_rvalid1", {7'd0, rvalid}, 8'h01);
        chk("warm_pinb1",   rdata, 8'h00);
        cyc();
        chk("warm_pinb2",   rdata, 8'h00);
        chk("warm_irq2",    {7'd0, pc_irq}, 8'h00);
        cyc();
        chk("warm_pinb3",   rdata, 8'h3F);
        chk("warm_irq3",    {7'd0, pc_irq}, 8'h00);
        rd_en = 1'b0;
        cyc();
        chk("rvalid_drop",  {7'd0, rvalid}, 8'h00);

        // Register writes and read-back
        wr(IO_ADDR_DDRB, 8'hFF);
        wr(IO_ADDR_PORTB, 8'hA5);
        chk("wr_pin_oe",   {2'b0, pin_oe},   8'h3F);
        chk("wr_port_out", {2'b0, port_out}, 8'h25);
        rd("rd_portb", IO_ADDR_PORTB, 8'h25);
        rd("rd_ddrb",  IO_ADDR_DDRB,  8'h3F);

        // PINB write toggles PORTB
        wr(IO_ADDR_PINB, 8'h03);
        chk("tgl_port_out", {2'b0, port_out}, 8'h26);
        wr(IO_ADDR_PINB, 8'h00);
        chk("tgl0_port_out", {2'b0, port_out}, 8'h26);

        // Masked pin change on bit 2
        wr(IO_ADDR_PCMSK, 8'h04);
        rd("rd_pcmsk", IO_ADDR_PCMSK, 8'h04);
        pin_in = 6'h3B;
        cyc();
        chk("pc_lat1", {7'd0, pc_irq}, 8'h00);
        cyc();
        chk("pc_lat2", {7'd0, pc_irq}, 8'h00);
        cyc();
        chk("pc_lat3", {7'd0, pc_irq}, 8'h01);
        cyc();
        chk("pc_held", {7'd0, pc_irq}, 8'h01);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("pc_ack", {7'd0, pc_irq}, 8'h00);
        rd("rd_pinb", IO_ADDR_PINB, 8'h3B);

        // Unmasked change on bit 3
        pin_in = 6'h33;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("pc_unmasked", {7'd0, pc_irq}, 8'h00);
        end

        // Set and acknowledge in the same cycle
        pin_in = 6'h37;
        cyc();
        cyc();
        chk("sim_pre", {7'd0, pc_irq}, 8'h00);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("sim_set_wins", {7'd0, pc_irq}, 8'h01);
        cyc();
        chk("sim_held", {7'd0, pc_irq}, 8'h01);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("sim_ack", {7'd0, pc_irq}, 8'h00);

        // Combined read and write to PORTB
        addr  = IO_ADDR_PORTB;
        wdata = 8'h11;
        wr_en = 1'b1;
        rd_en = 1'b1;
        cyc();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rw_rvalid",   {7'd0, rvalid},   8'h01);
        chk("rw_rdata",    rdata,            8'h26);
        chk("rw_port_out", {2'b0, port_out}, 8'h11);
        rd("rd_unmapped", 6'h20, 8'h00);

        // Back-to-back reads
        addr  = IO_ADDR_DDRB;
        rd_en = 1'b1;
        cyc();
        chk("b2b_ddrb", rdata, 8'h3F);
        addr = IO_ADDR_PCMSK;
        cyc();
        rd_en = 1'b0;
        chk("b2b_rvalid", {7'd0, rvalid}, 8'h01);
        chk("b2b_pcmsk",  rdata, 8'h04);

        wr(6'h20, 8'hFF);
        chk("unm_port_out", {2'b0, port_out}, 8'h11);
        chk("unm_pin_oe",   {2'b0, pin_oe},   8'h3F);

        // Reset mid-operation with irq pending and requests in flight
        pin_in = 6'h33;
        repeat (3) cyc();
        chk("mid_irq_pre", {7'd0, pc_irq}, 8'h01);
        rst   = 1'b1;
        addr  = IO_ADDR_PORTB;
        wdata = 8'h3F;
        rd_en = 1'b1;
        wr_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("mid_rvalid",   {7'd0, rvalid},   8'h00);
        chk("mid_irq",      {7'd0, pc_irq},   8'h00);
        chk("mid_port_out", {2'b0, port_out}, 8'h00);
        rst = 1'b0;

        // Synchroniser fill after reset must not raise an irq
        wr(IO_ADDR_PCMSK, 8'h3F);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rewarm_irq", {7'd0, pc_irq}, 8'h00);
        end
        pin_in = 6'h13;
        repeat (3) cyc();
        chk("post_warm_irq", {7'd0, pc_irq}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tiny_portb_regs.md
Name: tiny_portb_regs

Overview:
- MCU-side responder for the port-B pin interface of the ATtiny85 co-simulation model.
- Holds the AVR-style PORTB, DDRB, PINB and PCMSK registers and services single-beat read/write requests from the core model.
- Synchronises the pad inputs PB0..PB5 into PINB and drives output values and output enables back to the pad wrapper.
- Raises a pin-change interrupt request when any masked pin changes.

Parameters:
- NPINS, 6, number of port-B pins implemented (bits 7:NPINS read as 0).
- ADDR_PCMSK, 6'h15, I/O address of the pin-change mask register.
- ADDR_PINB, 6'h16, I/O address of PINB.
- ADDR_DDRB, 6'h17, I/O address of DDRB.
- ADDR_PORTB, 6'h18, I/O address of PORTB.
- SYNC_STAGES, 2, flops in the input synchroniser (minimum 2).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- addr  input  6  I/O register address.
- wr_en  input  1  write strobe; single cycle per write.
- wdata  input  8  write data.
- rd_en  input  1  read strobe; single cycle per read.
- rdata  output  8  registered read data.
- rvalid  output  1  high for exactly one cycle when rdata is valid.
- pin_in  input  NPINS  raw pad levels (asynchronous to clk).
- port_out  output  NPINS  PORTB value: drive level when the pin is an output, pull-up enable when it is an input.
- pin_oe  output  NPINS  DDRB value: 1 = output driver enabled.
- pc_irq  output  1  pin-change interrupt flag.
- irq_ack  input  1  clears pc_irq.

Behaviour:
- Reset (rst high at posedge):
  - PORTB, DDRB, PCMSK, all synchroniser flops, prev-sample register cleared to 0.
  - rdata = 8'h00, rvalid = 0, pc_irq = 0, warm-up counter = 0.
  - Reset wins over any same-cycle request; requests presented during reset are dropped.
- Synchroniser: pin_in passes through SYNC_STAGES flops to give pin_sync. PINB reads return pin_sync, so a pad edge is visible at PINB SYNC_STAGES cycles later.
- Writes (wr_en high) take effect at the same posedge:
  - ADDR_PORTB: PORTB <= wdata[NPINS-1:0].
  - ADDR_DDRB: DDRB <= wdata[NPINS-1:0].
  - ADDR_PCMSK: PCMSK <= wdata[NPINS-1:0].
  - ADDR_PINB: each bit written 1 toggles the corresponding PORTB bit; 0 bits leave PORTB unchanged; the PINB contents are not written.
  - Any other address: no effect.
- Reads (rd_en high at edge N):
  - rdata and rvalid are valid in cycle N+1; latency is 1.
  - rdata is zero-extended to 8 bits.
  - Unmapped addresses return 8'h00 with rvalid = 1.
  - rvalid deasserts the following cycle unless rd_en is held; back-to-back reads give one result per cycle.
- rd_en and wr_en in the same cycle: the write is performed, and the read returns the pre-write register value.
- port_out and pin_oe are direct register outputs; a write becomes visible the cycle after its edge.
- Pin-change detection:
  - prev <= pin_sync every cycle.
  - chg = |((pin_sync ^ prev) & PCMSK).
  - A 2-bit warm-up counter counts to SYNC_STAGES+1 after reset and saturates. chg is ignored until saturation, so reset-time garbage never raises an interrupt.
  - pc_irq is set on chg and cleared on irq_ack. If set and clear occur in the same cycle, set wins.
  - pc_irq is level-held until acknowledged.
  - PCMSK changes take effect for the comparison at the next edge.
- Pad loop-back: no combinational path from port_out or pin_oe to rdata. An output pin reads back only via pin_in through the synchroniser.
- Reset mid-operation: an outstanding rvalid is suppressed, pc_irq is cleared, and warm-up restarts.

Decomposition:
- Package tiny_io_pkg holds:
  - Address localparams (PCMSK/PINB/DDRB/PORTB).
  - NPINS default.
  - typedef logic [5:0] io_addr_t and logic [7:0] io_data_t.
- One sub-module: tiny_pin_sync, a parameterised SYNC_STAGES-deep, NPINS-wide synchroniser with synchronous reset. It is reused by other port blocks.

Test Plan:
- Reset check: hold rst 2 cycles with pin_in=6'h3F → port_out=0, pin_oe=0, pc_irq=0, rvalid=0. Read ADDR_PINB returns 8'h3F only after ≥2 cycles post-reset; pc_irq stays 0 throughout warm-up.
- Register writes: write DDRB=8'hFF, then PORTB=8'hA5 → pin_oe=6'h3F, port_out=6'h25. Read PORTB gives rdata=8'h25 one cycle after rd_en.
- Toggle: with PORTB=6'h25, write PINB=8'h03 → port_out=6'h26. Writing PINB=8'h00 leaves port_out at 6'h26.
- Pin change:
  - PCMSK=8'h04; toggle pin_in[2] → pc_irq rises SYNC_STAGES+1 cycles after the pad edge.
  - irq_ack clears pc_irq.
  - Toggling pin_in[3] (unmasked) → pc_irq stays 0.
- Simultaneous set/clear: a masked change asserts in the same cycle as irq_ack → pc_irq remains 1.
- Combined read/write: rd_en and wr_en together to PORTB (old value 6'h26, wdata 8'h11) → rdata=8'h26, port_out=6'h11. Read of address 6'h20 → rdata=8'h00, rvalid=1.
